// File: rtl/axi4_r_drop_ctrl.sv
// Injects SLVERR bursts for dropped L1/L2 transactions onto the slave R channel; pass-through otherwise.
// Latency: 1 cycle from drop accept to first injected beat; backpressure via drop_ready (FIFO full) and s_axi4_rready.
module axi4_r_drop_ctrl #(
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int AXI_USER_WIDTH  = 4,
  parameter int DROP_FIFO_DEPTH = 4
) (
  input  logic                      axi4_aclk,
  input  logic                      axi4_arstn,
  input  logic                      l1_drop_valid,
  input  logic [AXI_ID_WIDTH-1:0]   l1_drop_id,
  input  logic [7:0]                l1_drop_len,
  output logic                      l1_drop_ready,
  input  logic                      l2_drop_valid,
  input  logic [AXI_ID_WIDTH-1:0]   l2_drop_id,
  input  logic [7:0]                l2_drop_len,
  output logic                      l2_drop_ready,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi4_rid,
  input  logic [1:0]                m_axi4_rresp,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi4_rdata,
  input  logic                      m_axi4_rlast,
  input  logic [AXI_USER_WIDTH-1:0] m_axi4_ruser,
  input  logic                      m_axi4_rvalid,
  output logic                      m_axi4_rready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi4_rid,
  output logic [1:0]                s_axi4_rresp,
  output logic [AXI_DATA_WIDTH-1:0] s_axi4_rdata,
  output logic                      s_axi4_rlast,
  output logic [AXI_USER_WIDTH-1:0] s_axi4_ruser,
  output logic                      s_axi4_rvalid,
  input  logic                      s_axi4_rready,
  output logic                      drop_busy
);

  localparam int AW = $clog2(DROP_FIFO_DEPTH);

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] id;
    logic [7:0]              len;
  } drop_t;

  typedef enum logic {ST_PASS, ST_INJECT} state_t;

  state_t      state, state_nxt;
  drop_t       fifo_mem [DROP_FIFO_DEPTH];
  logic [AW:0] wptr, rptr, rptr_p1, fifo_cnt;
  logic        fifo_empty, fifo_full;
  logic        rr_l2;
  logic        grant_l1, grant_l2, push, pop;
  logic        start_inj;
  logic        in_burst;
  logic [7:0]  beat_cnt;
  drop_t       head, next_head, push_entry;

  assign fifo_cnt   = wptr - rptr;
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rptr_p1    = rptr + 1'b1;
  assign head       = fifo_mem[rptr[AW-1:0]];
  assign next_head  = fifo_mem[rptr_p1[AW-1:0]];

  // Ready uses the pre-pop fullness, so a slot freed this cycle is refilled next cycle at the earliest.
  assign l1_drop_ready = !fifo_full && (!l2_drop_valid || !rr_l2);
  assign l2_drop_ready = !fifo_full && (!l1_drop_valid ||  rr_l2);
  assign grant_l1      = l1_drop_valid && l1_drop_ready;
  assign grant_l2      = l2_drop_valid && l2_drop_ready;
  assign push          = grant_l1 || grant_l2;
  assign push_entry    = grant_l1 ? drop_t'{id: l1_drop_id, len: l1_drop_len}
                                  : drop_t'{id: l2_drop_id, len: l2_drop_len};

  assign start_inj = (state == ST_PASS) && !fifo_empty && !in_burst;
  assign pop       = (state == ST_INJECT) && s_axi4_rready && (beat_cnt == 8'd0);
  assign drop_busy = !fifo_empty || (state == ST_INJECT);

  always_ff @(posedge axi4_aclk) begin
    if (push) fifo_mem[wptr[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      wptr     <= '0;
      rptr     <= '0;
      rr_l2    <= 1'b0;
      in_burst <= 1'b0;
      beat_cnt <= 8'd0;
    end else begin
      if (push) begin
        wptr  <= wptr + 1'b1;
        rr_l2 <= grant_l1;
      end
      if (pop) rptr <= rptr_p1;
      if (m_axi4_rvalid && m_axi4_rready) in_burst <= !m_axi4_rlast;
      if (start_inj) begin
        beat_cnt <= head.len;
      end else if (state == ST_INJECT && s_axi4_rready) begin
        if (beat_cnt != 8'd0)
          beat_cnt <= beat_cnt - 8'd1;
        else if (fifo_cnt > (AW+1)'(1))
          beat_cnt <= next_head.len;
      end
    end
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) state <= ST_PASS;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_PASS:   if (start_inj) state_nxt = ST_INJECT;
      ST_INJECT: if (pop && fifo_cnt == (AW+1)'(1)) state_nxt = ST_PASS;
      default:   state_nxt = ST_PASS;
    endcase
  end

  // The hand-over cycle hides any master beat so neither side sees a half-completed handshake.
  always_comb begin
    s_axi4_rid    = m_axi4_rid;
    s_axi4_rresp  = m_axi4_rresp;
    s_axi4_rdata  = m_axi4_rdata;
    s_axi4_rlast  = m_axi4_rlast;
    s_axi4_ruser  = m_axi4_ruser;
    s_axi4_rvalid = m_axi4_rvalid;
    m_axi4_rready = s_axi4_rready;
    if (state == ST_INJECT) begin
      s_axi4_rid    = head.id;
      s_axi4_rresp  = 2'b10;
      s_axi4_rdata  = '0;
      s_axi4_rlast  = (beat_cnt == 8'd0);
      s_axi4_ruser  = '0;
      s_axi4_rvalid = 1'b1;
      m_axi4_rready = 1'b0;
    end else if (start_inj) begin
      s_axi4_rvalid = 1'b0;
      m_axi4_rready = 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_r_drop_ctrl.sv
// Directed vector bench for axi4_r_drop_ctrl: pass-through table plus multi-cycle drop sequences.
module tb_axi4_r_drop_ctrl;

  logic        axi4_aclk = 1'b0;
  logic        axi4_arstn;
  logic        l1_drop_valid, l2_drop_valid, l1_drop_ready, l2_drop_ready;
  logic [3:0]  l1_drop_id, l2_drop_id;
  logic [7:0]  l1_drop_len, l2_drop_len;
  logic [3:0]  m_axi4_rid, s_axi4_rid, m_axi4_ruser, s_axi4_ruser;
  logic [1:0]  m_axi4_rresp, s_axi4_rresp;
  logic [31:0] m_axi4_rdata, s_axi4_rdata;
  logic        m_axi4_rlast, s_axi4_rlast, m_axi4_rvalid, m_axi4_rready;
  logic        s_axi4_rvalid, s_axi4_rready, drop_busy;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
    logic [31:0] data;
  } beat_t;
  beat_t beats[$];

  typedef struct {
    logic        mv;
    logic [3:0]  mid;
    logic [31:0] mdata;
    logic        mlast;
    logic [1:0]  mresp;
    logic        srdy;
    logic        exp_sv;
    logic        exp_mrdy;
    logic [3:0]  exp_sid;
    logic [31:0] exp_sdata;
    logic        exp_slast;
    logic [1:0]  exp_sresp;
  } vec_t;
  vec_t vecs[5];

  axi4_r_drop_ctrl dut (
    .axi4_aclk(axi4_aclk), .axi4_arstn(axi4_arstn),
    .l1_drop_valid(l1_drop_valid), .l1_drop_id(l1_drop_id), .l1_drop_len(l1_drop_len),
    .l1_drop_ready(l1_drop_ready),
    .l2_drop_valid(l2_drop_valid), .l2_drop_id(l2_drop_id), .l2_drop_len(l2_drop_len),
    .l2_drop_ready(l2_drop_ready),
    .m_axi4_rid(m_axi4_rid), .m_axi4_rresp(m_axi4_rresp), .m_axi4_rdata(m_axi4_rdata),
    .m_axi4_rlast(m_axi4_rlast), .m_axi4_ruser(m_axi4_ruser), .m_axi4_rvalid(m_axi4_rvalid),
    .m_axi4_rready(m_axi4_rready),
    .s_axi4_rid(s_axi4_rid), .s_axi4_rresp(s_axi4_rresp), .s_axi4_rdata(s_axi4_rdata),
    .s_axi4_rlast(s_axi4_rlast), .s_axi4_ruser(s_axi4_ruser), .s_axi4_rvalid(s_axi4_rvalid),
    .s_axi4_rready(s_axi4_rready), .drop_busy(drop_busy)
  );

  always #5 axi4_aclk = ~axi4_aclk;

  always @(negedge axi4_aclk) begin
    if (axi4_arstn && s_axi4_rvalid && s_axi4_rready)
      beats.push_back('{s_axi4_rid, s_axi4_rresp, s_axi4_rlast, s_axi4_rdata});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget && beats.size() < n; i++) begin
      @(negedge axi4_aclk); #1;
    end
    check("beat_count", beats.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && drop_busy; i++) @(negedge axi4_aclk);
    check("idle", drop_busy, 1'b0);
  endtask

  initial begin
    int errs, lasts;
    vecs[0] = '{1'b1, 4'd5, 32'hA5A5_0001, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 4'd5, 32'hA5A5_0001, 1'b0, 2'b00};
    vecs[1] = '{1'b1, 4'd5, 32'h0000_1234, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 4'd5, 32'h0000_1234, 1'b0, 2'b00};
    vecs[2] = '{1'b0, 4'd2, 32'h0000_0000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 4'd2, 32'h0000_0000, 1'b0, 2'b00};
    vecs[3] = '{1'b1, 4'd9, 32'hFFFF_0000, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 4'd9, 32'hFFFF_0000, 1'b1, 2'b01};
    vecs[4] = '{1'b0, 4'd0, 32'h0000_0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0000_0000, 1'b0, 2'b00};

    axi4_arstn = 1'b0;
    l1_drop_valid = 0; l1_drop_id = 0; l1_drop_len = 0;
    l2_drop_valid = 0; l2_drop_id = 0; l2_drop_len = 0;
    m_axi4_rid = 0; m_axi4_rresp = 0; m_axi4_rdata = 0; m_axi4_rlast = 0; m_axi4_ruser = 0;
    m_axi4_rvalid = 0; s_axi4_rready = 0;
    repeat (3) @(posedge axi4_aclk);
    #1 axi4_arstn = 1'b1;
    @(negedge axi4_aclk);
    check("rst_l1_ready", l1_drop_ready, 1'b1);
    check("rst_l2_ready", l2_drop_ready, 1'b1);
    check("rst_busy", drop_busy, 1'b0);
    check("rst_s_rvalid", s_axi4_rvalid, 1'b0);

    // Pass-through table
    foreach (vecs[i]) begin
      @(posedge axi4_aclk); #1;
      m_axi4_rvalid = vecs[i].mv; m_axi4_rid = vecs[i].mid; m_axi4_rdata = vecs[i].mdata;
      m_axi4_rlast = vecs[i].mlast; m_axi4_rresp = vecs[i].mresp; s_axi4_rready = vecs[i].srdy;
      @(negedge axi4_aclk);
      check($sformatf("vec%0d_s_rvalid", i), s_axi4_rvalid, vecs[i].exp_sv);
      check($sformatf("vec%0d_m_rready", i), m_axi4_rready, vecs[i].exp_mrdy);
      check($sformatf("vec%0d_s_rid", i), s_axi4_rid, vecs[i].exp_sid);
      check($sformatf("vec%0d_s_rdata", i), s_axi4_rdata, vecs[i].exp_sdata);
      check($sformatf("vec%0d_s_rlast", i), s_axi4_rlast, vecs[i].exp_slast);
      check($sformatf("vec%0d_s_rresp", i), s_axi4_rresp, vecs[i].exp_sresp);
    end
    #1 beats.delete();

    // T1: single-beat L1 drop
    @(posedge axi4_aclk); #1;
    s_axi4_rready = 1; l1_drop_valid = 1; l1_drop_id = 4'd3; l1_drop_len = 8'd0;
    @(posedge axi4_aclk); #1;
    l1_drop_valid = 0;
    wait_beats(1, 20);
    if (beats.size() >= 1) begin
      check("t1_id", beats[0].id, 4'd3);
      check("t1_resp", beats[0].resp, 2'b10);
      check("t1_last", beats[0].last, 1'b1);
      check("t1_data", beats[0].data, 32'h0);
    end
    @(negedge axi4_aclk);
    check("t1_busy_fall", drop_busy, 1'b0);
    beats.delete();

    // T2: drop arrives mid master burst; injection waits for rlast
    for (int b = 0; b < 4; b++) begin
      @(posedge axi4_aclk); #1;
      m_axi4_rvalid = 1; m_axi4_rid = 4'd5; m_axi4_rdata = b; m_axi4_rresp = 0;
      m_axi4_rlast = (b == 3);
      l2_drop_valid = (b == 1); l2_drop_id = 4'd7; l2_drop_len = 8'd1;
    end
    @(posedge axi4_aclk); #1;
    m_axi4_rvalid = 0; m_axi4_rlast = 0; l2_drop_valid = 0;
    wait_beats(6, 40);
    if (beats.size() >= 6) begin
      errs = 0;
      for (int b = 0; b < 4; b++)
        if (beats[b].id != 4'd5 || beats[b].resp != 2'b00 || beats[b].data != b) errs++;
      check("t2_master_beats", errs, 0);
      check("t2_master_last", beats[3].last, 1'b1);
      check("t2_inj_id", {beats[4].id, beats[5].id}, {4'd7, 4'd7});
      check("t2_inj_resp", {beats[4].resp, beats[5].resp}, {2'b10, 2'b10});
      check("t2_inj_last", {beats[4].last, beats[5].last}, 2'b01);
    end
    wait_idle(20);
    beats.delete();

    // T3/T4: round-robin grants, then fill FIFO and release one slot
    @(posedge axi4_aclk); #1;
    s_axi4_rready = 0;
    l1_drop_valid = 1; l1_drop_id = 4'd1; l1_drop_len = 0;
    l2_drop_valid = 1; l2_drop_id = 4'd2; l2_drop_len = 0;
    @(negedge axi4_aclk);
    check("t3_g1", {l1_drop_ready, l2_drop_ready}, 2'b10);
    @(posedge axi4_aclk); #1; l1_drop_id = 4'd3;
    @(negedge axi4_aclk);
    check("t3_g2", {l1_drop_ready, l2_drop_ready}, 2'b01);
    @(posedge axi4_aclk); #1; l2_drop_id = 4'd4;
    @(negedge axi4_aclk);
    check("t3_g3", {l1_drop_ready, l2_drop_ready}, 2'b10);
    @(posedge axi4_aclk); #1; l1_drop_valid = 0;
    @(negedge axi4_aclk);
    check("t4_l2_fill", l2_drop_ready, 1'b1);
    @(posedge axi4_aclk); #1;
    l1_drop_valid = 1; l1_drop_id = 4'd5; l2_drop_id = 4'd6;
    @(negedge axi4_aclk);
    check("t4_full_ready", {l1_drop_ready, l2_drop_ready}, 2'b00);
    check("t4_busy", drop_busy, 1'b1);
    @(posedge axi4_aclk); #1; s_axi4_rready = 1;
    @(negedge axi4_aclk);
    check("t4_prepop_ready", {l1_drop_ready, l2_drop_ready}, 2'b00);
    @(posedge axi4_aclk); #1; s_axi4_rready = 0;
    @(negedge axi4_aclk);
    check("t4_freed_ready", {l1_drop_ready, l2_drop_ready}, 2'b10);
    @(posedge axi4_aclk); #1;
    l1_drop_valid = 0; l2_drop_valid = 0; s_axi4_rready = 1;
    wait_beats(5, 40);
    if (beats.size() >= 5) begin
      check("t3_order", {beats[0].id, beats[1].id, beats[2].id, beats[3].id, beats[4].id},
            {4'd1, 4'd2, 4'd3, 4'd4, 4'd5});
      errs = 0;
      foreach (beats[i]) if (beats[i].resp != 2'b10 || !beats[i].last) errs++;
      check("t3_resp_last", errs, 0);
    end
    wait_idle(20);
    beats.delete();

    // T5: 256-beat drop under random slave stalls
    @(posedge axi4_aclk); #1;
    s_axi4_rready = 0; l1_drop_valid = 1; l1_drop_id = 4'd10; l1_drop_len = 8'd255;
    @(posedge axi4_aclk); #1; l1_drop_valid = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge axi4_aclk); #1;
      s_axi4_rready = 1'($urandom_range(0, 1));
      @(negedge axi4_aclk);
      if (!drop_busy) break;
    end
    #1;
    check("t5_beats", beats.size(), 256);
    errs = 0; lasts = 0;
    foreach (beats[i]) begin
      if (beats[i].resp != 2'b10 || beats[i].id != 4'd10) errs++;
      if (beats[i].last) lasts++;
    end
    check("t5_payload", errs, 0);
    check("t5_last_count", lasts, 1);
    if (beats.size() == 256) check("t5_last_pos", beats[255].last, 1'b1);
    beats.delete();

    // T6: reset during beat 2 of 4
    @(posedge axi4_aclk); #1;
    s_axi4_rready = 1; l1_drop_valid = 1; l1_drop_id = 4'd8; l1_drop_len = 8'd3;
    @(posedge axi4_aclk); #1; l1_drop_valid = 0;
    wait_beats(1, 20);
    @(posedge axi4_aclk); #1;
    check("t6_inj_active", s_axi4_rresp, 2'b10);
    axi4_arstn = 0; m_axi4_rvalid = 1; m_axi4_rid = 4'd6; m_axi4_rlast = 1; m_axi4_rresp = 0;
    @(negedge axi4_aclk);
    check("t6_rst_s_rvalid", s_axi4_rvalid, 1'b1);
    check("t6_rst_s_rid", s_axi4_rid, 4'd6);
    check("t6_rst_busy", drop_busy, 1'b0);
    @(posedge axi4_aclk); #1; axi4_arstn = 1; m_axi4_rvalid = 0;
    @(negedge axi4_aclk);
    check("t6_post_s_rvalid", s_axi4_rvalid, 1'b0);
    check("t6_post_busy", drop_busy, 1'b0);
    check("t6_post_ready", {l1_drop_ready, l2_drop_ready}, 2'b11);
    @(posedge axi4_aclk); #1; m_axi4_rvalid = 1;
    @(negedge axi4_aclk);
    check("t6_pass_through", {s_axi4_rvalid, m_axi4_rready, s_axi4_rresp}, {1'b1, 1'b1, 2'b00});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
